// File: rtl/draw_pkg.sv
// Shared widths, screen defaults, FSM encoding and colours for the framebuffer draw arbiter.
package draw_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [COL_W-1:0] BLACK = 3'b000;
  localparam logic [COL_W-1:0] WHITE = 3'b111;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [X_W-1:0]   w;
    logic [Y_W-1:0]   h;
    logic [COL_W-1:0] colour;
  } rect_t;

  // A rectangle with no columns or no rows produces no pixels at all.
  function automatic logic rect_empty(input rect_t r);
    return (r.w == '0) || (r.h == '0);
  endfunction

endpackage

// File: rtl/draw_arbiter_rect_scanner.sv
// Raster walker for one latched rectangle: column/row counters, screen address, clip and last-pixel detect.
module rect_scanner
  import draw_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic           en,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           last,
  output logic           plot_en
);

  logic [X_W-1:0] cx_r;
  logic [Y_W-1:0] cy_r;
  logic           row_end_s;
  logic [X_W:0]   sum_x_s;
  logic [Y_W:0]   sum_y_s;

  assign row_end_s = (cx_r == (w - 8'd1));
  assign last      = row_end_s && (cy_r == (h - 7'd1));

  // One extra bit on each sum so a rectangle hanging off the right/bottom edge is clipped, not wrapped.
  assign sum_x_s = {1'b0, x0} + {1'b0, cx_r};
  assign sum_y_s = {1'b0, y0} + {1'b0, cy_r};

  assign pix_x   = sum_x_s[X_W-1:0];
  assign pix_y   = sum_y_s[Y_W-1:0];
  assign plot_en = (sum_x_s < 9'(SCREEN_W)) && (sum_y_s < 8'(SCREEN_H));

  // Row-major counters: cx sweeps each row, cy advances on row wrap, both clear at the last pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx_r <= '0;
      cy_r <= '0;
    end else if (start) begin
      cx_r <= '0;
      cy_r <= '0;
    end else if (en) begin
      if (last) begin
        cx_r <= '0;
        cy_r <= '0;
      end else if (row_end_s) begin
        cx_r <= '0;
        cy_r <= cy_r + 7'd1;
      end else begin
        cx_r <= cx_r + 8'd1;
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Shares the VGA framebuffer write port between rectangle-fill requesters.
// Define DRAW_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (index 0 highest).
module draw_arbiter
  import draw_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [N_REQ-1:0]         req,
  input  logic [X_W*N_REQ-1:0]     rect_x,
  input  logic [Y_W*N_REQ-1:0]     rect_y,
  input  logic [X_W*N_REQ-1:0]     rect_w,
  input  logic [Y_W*N_REQ-1:0]     rect_h,
  input  logic [COL_W*N_REQ-1:0]   rect_colour,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [COL_W-1:0]         vga_colour,
  output logic                     vga_plot
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             any_req_s;
  logic             start_s;
  logic             scan_s;
  logic [IDX_W-1:0] win_idx_s;
  logic [N_REQ-1:0] win_onehot_s;
  logic [N_REQ-1:0] win_r;
  rect_t            sel_s;
  rect_t            rect_r;
  logic [X_W-1:0]   pix_x_s;
  logic [Y_W-1:0]   pix_y_s;
  logic             last_s;
  logic             plot_en_s;

  assign any_req_s = |req;
  assign start_s   = (state_r == IDLE) && any_req_s;
  assign scan_s    = (state_r == SCAN);

`ifdef DRAW_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] cand_s;

  // Search from the pointer upward, wrapping; walking offsets downward lets the nearest one win.
  always_comb begin
    win_idx_s = '0;
    cand_s    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand_s    = IDX_W'((int'(ptr_r) + i) % N_REQ);
      win_idx_s = req[cand_s] ? cand_s : win_idx_s;
    end
  end

  // Pointer holds the index just past the most recent winner.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_r <= '0;
    end else if (start_s) begin
      ptr_r <= (int'(win_idx_s) == (N_REQ - 1)) ? '0 : (win_idx_s + IDX_W'(1));
    end
  end
`else
  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    win_idx_s = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      win_idx_s = req[i] ? IDX_W'(i) : win_idx_s;
    end
  end
`endif

  // Winner index to one-hot grant vector.
  always_comb begin
    win_onehot_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_onehot_s[i] = (win_idx_s == IDX_W'(i));
    end
  end

  // Pick the winner's slice out of the packed parameter buses.
  always_comb begin
    sel_s        = '0;
    sel_s.x      = rect_x[int'(win_idx_s)*X_W +: X_W];
    sel_s.y      = rect_y[int'(win_idx_s)*Y_W +: Y_W];
    sel_s.w      = rect_w[int'(win_idx_s)*X_W +: X_W];
    sel_s.h      = rect_h[int'(win_idx_s)*Y_W +: Y_W];
    sel_s.colour = rect_colour[int'(win_idx_s)*COL_W +: COL_W];
  end

  // Arbiter FSM next state; an empty rectangle goes straight to DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_nxt_s = rect_empty(sel_s) ? DONE : SCAN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN:    state_nxt_s = last_s ? DONE : SCAN;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus winner and parameter latch, captured on the grant edge only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      win_r   <= '0;
      rect_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (start_s) begin
        win_r  <= win_onehot_s;
        rect_r <= sel_s;
      end
    end
  end

  rect_scanner #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_scan (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start_s),
    .en      (scan_s),
    .x0      (rect_r.x),
    .y0      (rect_r.y),
    .w       (rect_r.w),
    .h       (rect_r.h),
    .pix_x   (pix_x_s),
    .pix_y   (pix_y_s),
    .last    (last_s),
    .plot_en (plot_en_s)
  );

  // Outputs decode from state and latched registers only, so async reset clears them at once.
  assign grant      = scan_s ? win_r : '0;
  assign done       = (state_r == DONE) ? win_r : '0;
  assign busy       = (state_r != IDLE);
  assign vga_x      = scan_s ? pix_x_s : '0;
  assign vga_y      = scan_s ? pix_y_s : '0;
  assign vga_colour = scan_s ? rect_r.colour : BLACK;
  assign vga_plot   = scan_s && plot_en_s;

endmodule
